fp_mean_cal: RTL and testbench

Parametrised floating-point calibration accumulator for the calibration path. On `go` it collects 2^LOG2_N IEEE-754 single-precision samples over a valid/ready handshake and sums them through a pipelined FP adder. It then outputs either the sum or the mean, selected by `mean_en`, as a one-cycle result pulse. Downstream offset/gain correction consumes the result.

---
 rtl/fp_cal_pkg.sv | 18 +
 rtl/fp_mean_cal_if.sv | 18 +
 rtl/fp_add_pipe.sv | 137 +++++++++++++
 rtl/fp_mean_cal.sv | 107 ++++++++++
 tb/tb_fp_mean_cal.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_cal_pkg.sv
// rtl/fp_cal_pkg.sv - shared FP field widths, constants and FSM states
// for the calibration accumulator.
package fp_cal_pkg;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   localparam logic [31:0] FP_MAX_POS = 32'h7F7FFFFF;
   localparam logic [31:0] FP_ZERO    = 32'h00000000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ADD,
      S_SCALE,
      S_DONE
   } state_t;
endpackage

// File: rtl/fp_mean_cal_if.sv
// rtl/fp_mean_cal_if.sv - sample handshake and result bus of the
// calibration accumulator.
interface fp_mean_cal_if;
   logic        go;
   logic        mean_en;
   logic [31:0] data;
   logic        valid;
   logic        ready;
   logic        busy;
   logic [31:0] result;
   logic        done;
   logic        err;

   modport master (output go, mean_en, data, valid,
                   input  ready, busy, result, done, err);
   modport slave  (input  go, mean_en, data, valid,
                   output ready, busy, result, done, err);
endinterface

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - 3-stage single-precision adder (align/add, normalise,
// round/pack) with denormal flush, RNE rounding and saturation.
module fp_add_pipe
   import fp_cal_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_valid,
   output logic [31:0] o_sum,
   output logic        o_err
);
   logic        w_a_bad, w_b_bad, w_a_zero, w_b_zero, w_swap;
   logic [31:0] w_a_cln, w_b_cln, w_big, w_small;
   logic [23:0] w_big_m, w_small_m;
   logic [7:0]  w_d;
   logic [49:0] w_wide;
   logic [26:0] w_small_ext;

   assign w_a_bad   = &i_a[30:23];
   assign w_b_bad   = &i_b[30:23];
   assign w_a_zero  = (i_a[30:23] == 8'd0) | w_a_bad;
   assign w_b_zero  = (i_b[30:23] == 8'd0) | w_b_bad;
   assign w_a_cln   = w_a_zero ? {i_a[31], 31'b0} : i_a;
   assign w_b_cln   = w_b_zero ? {i_b[31], 31'b0} : i_b;
   assign w_swap    = w_b_cln[30:0] > w_a_cln[30:0];
   assign w_big     = w_swap ? w_b_cln : w_a_cln;
   assign w_small   = w_swap ? w_a_cln : w_b_cln;
   assign w_big_m   = {|w_big[30:23], w_big[22:0]};
   assign w_small_m = {|w_small[30:23], w_small[22:0]};
   assign w_d       = w_big[30:23] - w_small[30:23];
   assign w_wide    = {w_small_m, 26'b0} >> w_d;
   // Small operand keeps guard/round bits plus a sticky OR of everything shifted out.
   assign w_small_ext = (w_d > 8'd26) ? {26'b0, |w_small_m}
                                      : {w_wide[49:24], |w_wide[23:0]};

   logic        r1_valid, r1_sign, r1_sub, r1_err;
   logic [7:0]  r1_exp;
   logic [26:0] r1_big, r1_small;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r1_valid <= 1'b0;
         r1_sign  <= 1'b0;
         r1_sub   <= 1'b0;
         r1_err   <= 1'b0;
         r1_exp   <= '0;
         r1_big   <= '0;
         r1_small <= '0;
      end else begin
         r1_valid <= i_valid;
         r1_sign  <= w_big[31];
         r1_sub   <= w_big[31] ^ w_small[31];
         r1_err   <= w_a_bad | w_b_bad;
         r1_exp   <= w_big[30:23];
         r1_big   <= {w_big_m, 3'b0};
         r1_small <= w_small_ext;
      end
   end

   logic [27:0] w_sum;
   logic [4:0]  w_lz;
   logic [26:0] w_norm;
   logic [9:0]  w_nexp;

   assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                         : ({1'b0, r1_big} + {1'b0, r1_small});

   always_comb begin
      w_lz = 5'd27;
      for (int i = 0; i <= 26; i++) begin
         if (w_sum[i]) w_lz = 5'(26 - i);
      end
   end

   always_comb begin
      w_norm = '0;
      w_nexp = '0;
      if (w_sum[27]) begin
         w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
         w_nexp = {2'b0, r1_exp} + 10'd1;
      end else begin
         w_norm = w_sum[26:0] << w_lz;
         w_nexp = {2'b0, r1_exp} - {5'b0, w_lz};
      end
   end

   logic        r2_valid, r2_sign, r2_zero, r2_err;
   logic [8:0]  r2_exp;
   logic [26:0] r2_man;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r2_valid <= 1'b0;
         r2_sign  <= 1'b0;
         r2_zero  <= 1'b0;
         r2_err   <= 1'b0;
         r2_exp   <= '0;
         r2_man   <= '0;
      end else begin
         r2_valid <= r1_valid;
         r2_err   <= r1_err;
         r2_exp   <= w_nexp[8:0];
         r2_man   <= w_norm;
         // Exact cancellation is +0; exponent underflow flushes to signed zero.
         r2_zero  <= (w_sum == 28'd0) | w_nexp[9] | (w_nexp == 10'd0);
         r2_sign  <= (w_sum == 28'd0) ? 1'b0 : r1_sign;
      end
   end

   logic        w_rup, w_ovf;
   logic [24:0] w_rman;
   logic [8:0]  w_rexp;
   logic [22:0] w_frac;

   assign w_rup  = r2_man[2] & (r2_man[1] | r2_man[0] | r2_man[3]);
   assign w_rman = {1'b0, r2_man[26:3]} + 25'(w_rup);
   assign w_rexp = r2_exp + 9'(w_rman[24]);
   assign w_frac = w_rman[24] ? w_rman[23:1] : w_rman[22:0];
   assign w_ovf  = !r2_zero && (w_rexp >= 9'd255);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_sum   <= FP_ZERO;
         o_err   <= 1'b0;
      end else begin
         o_valid <= r2_valid;
         o_err   <= r2_err | w_ovf;
         if (r2_zero)    o_sum <= {r2_sign, 31'b0};
         else if (w_ovf) o_sum <= {r2_sign, FP_MAX_POS[30:0]};
         else            o_sum <= {r2_sign, w_rexp[7:0], w_frac};
      end
   end
endmodule

// File: rtl/fp_mean_cal.sv
// rtl/fp_mean_cal.sv - collects 2^LOG2_N float samples, accumulates them and
// emits the sum or mean as a one-cycle result pulse.
module fp_mean_cal
   import fp_cal_pkg::*;
#(
   parameter int LOG2_N = 4
)(
   input  logic          i_clk,
   input  logic          i_rst,
   fp_mean_cal_if.slave  bus
);
   localparam int N     = 1 << LOG2_N;
   localparam int CNT_W = LOG2_N + 1;

   state_t             r_state;
   logic [31:0]        r_acc, r_result;
   logic [CNT_W-1:0]   r_count;
   logic               r_mean_en, r_ready, r_busy, r_done, r_err;
   logic               w_accept, w_add_valid, w_add_err;
   logic [31:0]        w_add_sum, w_scaled;

   assign w_accept = (r_state == S_WAIT) & r_ready & bus.valid;

   fp_add_pipe u_add (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (w_accept),
      .i_a     (r_acc),
      .i_b     (bus.data),
      .o_valid (w_add_valid),
      .o_sum   (w_add_sum),
      .o_err   (w_add_err)
   );

   // Division by N is an exponent decrement; anything that would go denormal flushes.
   always_comb begin
      w_scaled = r_acc;
      if (r_mean_en && (r_acc[30:23] != 8'd0)) begin
         if (r_acc[30:23] <= 8'(LOG2_N)) w_scaled = {r_acc[31], 31'b0};
         else w_scaled = {r_acc[31], r_acc[30:23] - 8'(LOG2_N), r_acc[22:0]};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_acc     <= FP_ZERO;
         r_result  <= FP_ZERO;
         r_count   <= '0;
         r_mean_en <= 1'b0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_add_valid && w_add_err) r_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.go) begin
                  r_acc     <= FP_ZERO;
                  r_count   <= '0;
                  r_err     <= 1'b0;
                  r_mean_en <= bus.mean_en;
                  r_busy    <= 1'b1;
                  r_ready   <= 1'b1;
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.valid) begin
                  r_ready <= 1'b0;
                  r_state <= S_ADD;
               end
            end
            S_ADD: begin
               if (w_add_valid) begin
                  r_acc   <= w_add_sum;
                  r_count <= r_count + 1'b1;
                  if (r_count == CNT_W'(N - 1)) begin
                     r_state <= S_SCALE;
                  end else begin
                     r_ready <= 1'b1;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_SCALE: begin
               r_result <= w_scaled;
               r_done   <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ready  = r_ready;
   assign bus.busy   = r_busy;
   assign bus.result = r_result;
   assign bus.done   = r_done;
   assign bus.err    = r_err;
endmodule

// File: tb/tb_fp_mean_cal.sv
// tb/tb_fp_mean_cal.sv - self-checking bench for fp_mean_cal against an
// exact-arithmetic reference model.
module tb_fp_mean_cal;
   import fp_cal_pkg::*;

   localparam int LOG2_N = 4;
   localparam int N      = 1 << LOG2_N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   logic [31:0] samp [N];
   int          acc_edge [N];
   int          done_edge;

   fp_mean_cal_if bus ();

   fp_mean_cal #(.LOG2_N(LOG2_N)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Exact value in units of 2^-150; denormals and Inf/NaN count as zero.
   function automatic logic signed [299:0] to_fixed(input logic [31:0] f);
      logic signed [299:0] v;
      if (f[30:23] == 8'd0 || f[30:23] == 8'hFF) return '0;
      v = 300'({1'b1, f[22:0]});
      v = v <<< f[30:23];
      return f[31] ? -v : v;
   endfunction

   function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b);
      logic signed [299:0] s;
      logic [299:0] mag, mant, rem, half;
      logic er, sg;
      int p, e;
      er = (&a[30:23]) | (&b[30:23]);
      s = to_fixed(a) + to_fixed(b);
      if (s == 0) return {er, 32'h0};
      sg  = (s < 0);
      mag = sg ? -s : s;
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      e = p - 23;
      if (e <= 0) return {er, sg, 31'b0};
      mant = mag >> e;
      rem  = mag - (mant << e);
      half = 300'd1 << (e - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 1;
      if (mant[24]) begin
         mant = mant >> 1;
         e++;
      end
      if (e >= 255) return {1'b1, sg, 31'h7F7FFFFF};
      return {er, sg, 8'(e), mant[22:0]};
   endfunction

   function automatic logic [32:0] model_run(input logic men);
      logic [31:0] acc;
      logic [32:0] r;
      logic er;
      acc = 32'h0;
      er  = 1'b0;
      for (int i = 0; i < N; i++) begin
         r   = model_add(acc, samp[i]);
         acc = r[31:0];
         er  = er | r[32];
      end
      if (men && acc[30:23] != 8'd0) begin
         if (acc[30:23] <= 8'(LOG2_N)) acc = {acc[31], 31'b0};
         else acc = {acc[31], acc[30:23] - 8'(LOG2_N), acc[22:0]};
      end
      return {er, acc};
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
   endfunction

   task automatic do_run(input logic men, input int n_stop, input logic go_mid,
                         output logic [31:0] res, output logic er);
      int budget;
      res = '0;
      er = 1'b0;
      done_edge = -1;
      @(negedge clk);
      bus.go = 1'b1;
      bus.mean_en = men;
      @(negedge clk);
      bus.go = 1'b0;
      bus.mean_en = ~men;
      for (int i = 0; i < n_stop; i++) begin
         bus.data  = samp[i];
         bus.valid = 1'b1;
         budget = 20;
         while (!bus.ready && budget > 0) begin
            @(negedge clk);
            budget--;
         end
         if (!bus.ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout sample=%0d ready=%b required=1", i, bus.ready);
            bus.valid = 1'b0;
            return;
         end
         acc_edge[i] = cyc + 1;
         @(negedge clk);
         checks++;
         if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop sample=%0d got=%b required=0", i, bus.ready);
         end
         if (go_mid && i == 0) begin
            bus.go = 1'b1;
            @(negedge clk);
            bus.go = 1'b0;
         end
      end
      bus.valid = 1'b0;
      if (n_stop < N) return;
      budget = 20;
      while (bus.done !== 1'b1 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (bus.done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL done_timeout got=%b required=1", bus.done);
         return;
      end
      done_edge = cyc;
      res = bus.result;
      er  = bus.err;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.ready, bus.busy, bus.done, bus.err, bus.result} !== 36'h0) begin
         errors++;
         $display("FAIL reset_state got=%h required=0",
                  {bus.ready, bus.busy, bus.done, bus.err, bus.result});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_const_mean_sum();
      logic [31:0] res;
      logic er;
      for (int i = 0; i < N; i++) samp[i] = 32'h40000000;
      do_run(1'b1, N, 1'b0, res, er);
      checks++;
      if ({er, res} !== {1'b0, 32'h40000000}) begin
         errors++;
         $display("FAIL const_mean got=%b/%h required=0/40000000", er, res);
      end
      do_run(1'b0, N, 1'b0, res, er);
      checks++;
      if ({er, res} !== {1'b0, 32'h42000000}) begin
         errors++;
         $display("FAIL const_sum got=%b/%h required=0/42000000", er, res);
      end
   endtask

   task automatic test_alternating();
      logic [31:0] res;
      logic er;
      for (int i = 0; i < N; i++) samp[i] = (i % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
      do_run(1'b1, N, 1'b0, res, er);
      checks++;
      if ({er, res} !== 33'h0) begin
         errors++;
         $display("FAIL alternating got=%b/%h required=0/00000000", er, res);
      end
   endtask

   task automatic test_round_even();
      logic [31:0] res;
      logic er;
      for (int i = 0; i < N; i++) samp[i] = 32'h0;
      samp[0] = 32'h3F800000;
      samp[1] = 32'h33800000;
      do_run(1'b0, N, 1'b0, res, er);
      checks++;
      if (res !== 32'h3F800000) begin
         errors++;
         $display("FAIL tie_even got=%h required=3F800000", res);
      end
      samp[0] = 32'h3F800001;
      do_run(1'b0, N, 1'b0, res, er);
      checks++;
      if (res !== 32'h3F800002) begin
         errors++;
         $display("FAIL tie_odd got=%h required=3F800002", res);
      end
   endtask

   task automatic test_inf_err();
      logic [31:0] res;
      logic er;
      for (int i = 0; i < N; i++) samp[i] = 32'h3F800000;
      samp[5] = 32'h7F800000;
      do_run(1'b0, N, 1'b0, res, er);
      checks++;
      if ({er, res} !== {1'b1, 32'h41700000}) begin
         errors++;
         $display("FAIL inf_err got=%b/%h required=1/41700000", er, res);
      end
      samp[5] = 32'h3F800000;
      do_run(1'b0, N, 1'b0, res, er);
      checks++;
      if ({er, res} !== {1'b0, 32'h41800000}) begin
         errors++;
         $display("FAIL err_cleared got=%b/%h required=0/41800000", er, res);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] res;
      logic er;
      logic [32:0] exp_v;
      for (int i = 0; i < N; i++) samp[i] = 32'h7F000000;
      exp_v = model_run(1'b1);
      do_run(1'b1, N, 1'b0, res, er);
      checks++;
      if ({er, res} !== exp_v || exp_v !== {1'b1, 32'h7D7FFFFF}) begin
         errors++;
         $display("FAIL overflow got=%b/%h required=%b/%h", er, res, exp_v[32], exp_v[31:0]);
      end
   endtask

   task automatic test_back_to_back_go_ignored();
      logic [31:0] res;
      logic er;
      logic [32:0] exp_v;
      int bad_gap;
      for (int i = 0; i < N; i++) samp[i] = rand_fp();
      exp_v = model_run(1'b1);
      do_run(1'b1, N, 1'b1, res, er);
      checks++;
      if ({er, res} !== exp_v) begin
         errors++;
         $display("FAIL go_ignored_result got=%b/%h required=%b/%h", er, res, exp_v[32], exp_v[31:0]);
      end
      bad_gap = 0;
      for (int i = 1; i < N; i++) if (acc_edge[i] - acc_edge[i-1] != 4) bad_gap++;
      checks++;
      if (bad_gap != 0) begin
         errors++;
         $display("FAIL accept_spacing bad_gaps=%0d required=0", bad_gap);
      end
      checks++;
      if (done_edge - acc_edge[N-1] != 4) begin
         errors++;
         $display("FAIL done_latency got=%0d required=4", done_edge - acc_edge[N-1]);
      end
      @(negedge clk);
      checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         errors++;
         $display("FAIL done_pulse got=%b required=00", {bus.done, bus.busy});
      end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] res;
      logic er;
      logic [32:0] exp_v;
      int seen_done;
      for (int i = 0; i < N; i++) samp[i] = rand_fp();
      do_run(1'b0, 7, 1'b0, res, er);
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.ready, bus.busy, bus.done, bus.err, bus.result} !== 36'h0) begin
         errors++;
         $display("FAIL midrun_reset got=%h required=0",
                  {bus.ready, bus.busy, bus.done, bus.err, bus.result});
      end
      seen_done = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.done) seen_done++;
      end
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) seen_done++;
      end
      checks++;
      if (seen_done != 0) begin
         errors++;
         $display("FAIL midrun_no_done got=%0d required=0", seen_done);
      end
      exp_v = model_run(1'b0);
      do_run(1'b0, N, 1'b0, res, er);
      checks++;
      if ({er, res} !== exp_v) begin
         errors++;
         $display("FAIL after_reset_run got=%b/%h required=%b/%h", er, res, exp_v[32], exp_v[31:0]);
      end
   endtask

   task automatic test_random();
      logic [31:0] res;
      logic er, men;
      logic [32:0] exp_v;
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < N; i++) samp[i] = rand_fp();
         men = 1'($urandom);
         exp_v = model_run(men);
         do_run(men, N, 1'b0, res, er);
         checks++;
         if ({er, res} !== exp_v) begin
            errors++;
            $display("FAIL random_run%0d mean_en=%b got=%b/%h required=%b/%h",
                     r, men, er, res, exp_v[32], exp_v[31:0]);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1);
   end

   initial begin
      bus.go = 1'b0;
      bus.mean_en = 1'b0;
      bus.data = '0;
      bus.valid = 1'b0;
      test_reset();
      test_const_mean_sum();
      test_alternating();
      test_round_even();
      test_inf_err();
      test_overflow();
      test_back_to_back_go_ignored();
      test_reset_midrun();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
